// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared types and constants for the LC-3 memory responder
package lc3_mem_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;

    localparam logic [15:0] MMIO_SW_HEX_ADDR = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DONE,
        WR_WAIT,
        WR_DONE
    } state_t;

endpackage

// File: rtl/lc3_mem_responder_if.sv
// rtl/lc3_mem_responder_if.sv - CPU memory strobe bus between initiator and responder
interface lc3_mem_responder_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] Data_from_CPU;
    logic              Mem_OE;
    logic              Mem_WE;
    logic [DATA_W-1:0] Switches;
    logic [DATA_W-1:0] Data_to_CPU;
    logic              Mem_Rdy;
    logic [DATA_W-1:0] HEX_Data;
    logic              Busy;

    modport master (
        output ADDR, Data_from_CPU, Mem_OE, Mem_WE, Switches,
        input  Data_to_CPU, Mem_Rdy, HEX_Data, Busy
    );

    modport slave (
        input  ADDR, Data_from_CPU, Mem_OE, Mem_WE, Switches,
        output Data_to_CPU, Mem_Rdy, HEX_Data, Busy
    );
endinterface

// File: rtl/lc3_mem_array.sv
// rtl/lc3_mem_array.sv - single-port word RAM, write enable, registered read
module lc3_mem_array #(
    parameter int DATA_W     = 16,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Read register only moves on a read, so it doubles as the held read-data output.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/lc3_mem_responder.sv
// rtl/lc3_mem_responder.sv - wait-state memory responder for Mem_OE/Mem_WE strobes
// Optional switch/hex I/O word enabled by LC3_MEM_RESPONDER_MMIO_EN.
module lc3_mem_responder
    import lc3_mem_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 3
) (
    input  logic                Clk,
    input  logic                Reset,
    lc3_mem_responder_if.slave  bus
);

`ifdef LC3_MEM_RESPONDER_MMIO_EN
    localparam int LATCH_W = ADDR_W;
`else
    localparam int LATCH_W = DEPTH_LOG2;
`endif
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [LATCH_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               rdy_q, rdy_d;
    logic [DATA_W-1:0]  hex_q, hex_d;
    logic               io_rd_q, io_rd_d;
    logic [DATA_W-1:0]  io_data_q, io_data_d;

    logic [LATCH_W-1:0] addr_sel;
    logic [DATA_W-1:0]  wdata_sel;
    logic               is_io;
    logic               complete_rd;
    logic               complete_wr;
    logic               ram_we;
    logic               ram_re;
    logic [DATA_W-1:0]  ram_rdata;
    logic [3:0]         cnt_inc;

    // On the entry edge the latch is still being loaded, so use the live bus values.
    assign addr_sel  = (state_q == IDLE) ? bus.ADDR[LATCH_W-1:0] : addr_q;
    assign wdata_sel = (state_q == IDLE) ? bus.Data_from_CPU : wdata_q;
    assign cnt_inc   = cnt_q + 4'd1;

`ifdef LC3_MEM_RESPONDER_MMIO_EN
    assign is_io = (addr_sel == LATCH_W'(MMIO_SW_HEX_ADDR));
`else
    assign is_io = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdy_d       = rdy_q;
        hex_d       = hex_q;
        io_rd_d     = io_rd_q;
        io_data_d   = io_data_q;
        complete_rd = 1'b0;
        complete_wr = 1'b0;
        ram_we      = 1'b0;
        ram_re      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.Mem_WE) begin
                    addr_d  = bus.ADDR[LATCH_W-1:0];
                    wdata_d = bus.Data_from_CPU;
                    cnt_d   = 4'd1;
                    state_d = WR_WAIT;
                    complete_wr = (WAIT_LAST == 4'd1);
                end else if (bus.Mem_OE) begin
                    addr_d  = bus.ADDR[LATCH_W-1:0];
                    cnt_d   = 4'd1;
                    state_d = RD_WAIT;
                    complete_rd = (WAIT_LAST == 4'd1);
                end
            end
            RD_WAIT: begin
                if (!bus.Mem_OE) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d       = cnt_inc;
                    complete_rd = (cnt_inc == WAIT_LAST);
                end
            end
            WR_WAIT: begin
                if (!bus.Mem_WE) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d       = cnt_inc;
                    complete_wr = (cnt_inc == WAIT_LAST);
                end
            end
            RD_DONE: begin
                if (!bus.Mem_OE) begin
                    state_d = IDLE;
                    rdy_d   = 1'b0;
                    cnt_d   = 4'd0;
                end
            end
            WR_DONE: begin
                if (!bus.Mem_WE) begin
                    state_d = IDLE;
                    rdy_d   = 1'b0;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
                rdy_d   = 1'b0;
            end
        endcase

        if (complete_rd) begin
            state_d = RD_DONE;
            rdy_d   = 1'b1;
            io_rd_d = is_io;
            if (is_io) begin
                io_data_d = bus.Switches;
            end else begin
                ram_re = 1'b1;
            end
        end

        if (complete_wr) begin
            state_d = WR_DONE;
            rdy_d   = 1'b1;
            if (is_io) begin
                hex_d = wdata_sel;
            end else begin
                ram_we = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdy_q     <= 1'b0;
            hex_q     <= '0;
            io_rd_q   <= 1'b0;
            io_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdy_q     <= rdy_d;
            hex_q     <= hex_d;
            io_rd_q   <= io_rd_d;
            io_data_q <= io_data_d;
        end
    end

    lc3_mem_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (Clk),
        .rst   (Reset),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (addr_sel[DEPTH_LOG2-1:0]),
        .wdata (wdata_sel),
        .rdata (ram_rdata)
    );

    assign bus.Data_to_CPU = io_rd_q ? io_data_q : ram_rdata;
    assign bus.Mem_Rdy     = rdy_q;
    assign bus.HEX_Data    = hex_q;
    assign bus.Busy        = (state_q != IDLE);

endmodule
